// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares the single 16Kx8 system ROM (registered read, one-cycle latency)
// between the 6502 fetch path and a debug/loader read port. One read is in
// flight at a time. The winner gets a one-cycle gnt pulse. The byte returns
// later with a one-cycle rvalid pulse. Everything is clocked on phi0.
//
// Optional feature macro: ROM_ARB_DBG_EN
//   defined   : debug port and starvation guard implemented.
//   undefined : debug outputs tied to 0, debug inputs ignored, CPU only.
//
// Ports
//   phi0, rst_b             clock (rising edge), synchronous active-low reset
//   cpu_req/addr            CPU read request (held until gnt) and address
//   cpu_gnt/rvalid/rdata    grant pulse, data-valid pulse, returned byte
//   dbg_*                   debug port, same semantics as the CPU port
//   rom_A/CS_b/OE_b         ROM address and active-low controls
//   rom_Dout                ROM registered data output
//   busy                    high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int WAIT_CYCLES  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              phi0,
  input  logic              rst_b,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rom_A,
  output logic              rom_CS_b,
  output logic              rom_OE_b,
  input  logic [DATA_W-1:0] rom_Dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  // Last WAIT count value before moving on to CAPTURE.
  localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   rom_a_q, rom_a_d;
  logic                cs_b_q, cs_b_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_win;
  logic                dbg_win;

`ifdef ROM_ARB_DBG_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                owner_q, owner_d;   // 1: debug owns the access
  logic [3:0]          starve_q, starve_d;
  logic                dbg_gnt_q, dbg_gnt_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

  // Debug wins when the CPU is absent, or once the CPU has been granted
  // STARVE_LIMIT times in a row while debug was waiting.
  assign dbg_win = dbg_req && (!cpu_req || (starve_q >= STARVE_MAX));
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_addr};
  assign dbg_win    = 1'b0;
`endif

  assign cpu_win = cpu_req && !dbg_win;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rom_a_d      = rom_a_q;
    cs_b_d       = cs_b_q;
    cpu_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
`ifdef ROM_ARB_DBG_EN
    owner_d      = owner_q;
    starve_d     = starve_q;
    dbg_gnt_d    = 1'b0;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        // The ROM controls stay low through the idle cycle that follows a
        // capture and are released here unless a new access starts.
        cs_b_d = 1'b1;
`ifdef ROM_ARB_DBG_EN
        if (!dbg_req || dbg_win) begin
          starve_d = 4'd0;
        end else if (cpu_win) begin
          starve_d = starve_q + 4'd1;
        end
`endif
        if (cpu_win || dbg_win) begin
          cs_b_d     = 1'b0;
          wait_cnt_d = 3'd0;
          state_d    = S_ISSUE;
`ifdef ROM_ARB_DBG_EN
          owner_d    = dbg_win;
          dbg_gnt_d  = dbg_win;
          rom_a_d    = dbg_win ? dbg_addr : cpu_addr;
`else
          rom_a_d    = cpu_addr;
`endif
          cpu_gnt_d  = cpu_win;
        end
      end
      S_ISSUE: begin
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      S_CAPTURE: begin
`ifdef ROM_ARB_DBG_EN
        if (owner_q) begin
          dbg_rdata_d  = rom_Dout;
          dbg_rvalid_d = 1'b1;
        end else begin
          cpu_rdata_d  = rom_Dout;
          cpu_rvalid_d = 1'b1;
        end
`else
        cpu_rdata_d  = rom_Dout;
        cpu_rvalid_d = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge phi0) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 3'd0;
      rom_a_q      <= '0;
      cs_b_q       <= 1'b1;
      cpu_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
`ifdef ROM_ARB_DBG_EN
      owner_q      <= 1'b0;
      starve_q     <= 4'd0;
      dbg_gnt_q    <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rom_a_q      <= rom_a_d;
      cs_b_q       <= cs_b_d;
      cpu_gnt_q    <= cpu_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
`ifdef ROM_ARB_DBG_EN
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      dbg_gnt_q    <= dbg_gnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
`endif
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
`ifdef ROM_ARB_DBG_EN
  assign dbg_gnt    = dbg_gnt_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
`else
  assign dbg_gnt    = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = '0;
`endif
  assign rom_A    = rom_a_q;
  assign rom_CS_b = cs_b_q;
  assign rom_OE_b = cs_b_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for rom_port_arbiter. Two instances share one stimulus stream:
// u_dut0 with WAIT_CYCLES=0 and u_dut1 with WAIT_CYCLES=3. Each has its own
// copy of the registered-read ROM. A transaction-level reference model
// (grant decision + cycle count since the grant edge) predicts every output
// each cycle.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

`ifdef ROM_ARB_DBG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif
  localparam int STARVE = 4;
  localparam int WC [2] = '{0, 3};

  logic        phi0 = 1'b0;
  logic        rst_b;
  logic        cpu_req, dbg_req;
  logic [13:0] cpu_addr, dbg_addr;

  logic        cpu_gnt_o [2];
  logic        cpu_rv_o  [2];
  logic [7:0]  cpu_rd_o  [2];
  logic        dbg_gnt_o [2];
  logic        dbg_rv_o  [2];
  logic [7:0]  dbg_rd_o  [2];
  logic [13:0] rom_a_o   [2];
  logic        rom_cs_o  [2];
  logic        rom_oe_o  [2];
  logic [7:0]  rom_dout  [2];
  logic        busy_o    [2];

  logic [7:0]  mem [0:16383];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, per instance
  bit          m_active [2];
  int          m_t      [2];
  bit          m_owner  [2];
  logic [13:0] m_a      [2];
  int          m_cnt    [2];
  bit          m_cs_b   [2];
  bit          m_cpu_gnt[2];
  bit          m_dbg_gnt[2];
  bit          m_cpu_rv [2];
  bit          m_dbg_rv [2];
  logic [7:0]  m_cpu_rd [2];
  logic [7:0]  m_dbg_rd [2];

  always #5 phi0 = ~phi0;

  rom_port_arbiter #(.ADDR_W(14), .DATA_W(8), .WAIT_CYCLES(0), .STARVE_LIMIT(STARVE)) u_dut0 (
    .phi0(phi0), .rst_b(rst_b),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_gnt(cpu_gnt_o[0]), .cpu_rvalid(cpu_rv_o[0]), .cpu_rdata(cpu_rd_o[0]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt_o[0]), .dbg_rvalid(dbg_rv_o[0]), .dbg_rdata(dbg_rd_o[0]),
    .rom_A(rom_a_o[0]), .rom_CS_b(rom_cs_o[0]), .rom_OE_b(rom_oe_o[0]),
    .rom_Dout(rom_dout[0]), .busy(busy_o[0])
  );

  rom_port_arbiter #(.ADDR_W(14), .DATA_W(8), .WAIT_CYCLES(3), .STARVE_LIMIT(STARVE)) u_dut1 (
    .phi0(phi0), .rst_b(rst_b),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_gnt(cpu_gnt_o[1]), .cpu_rvalid(cpu_rv_o[1]), .cpu_rdata(cpu_rd_o[1]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt_o[1]), .dbg_rvalid(dbg_rv_o[1]), .dbg_rdata(dbg_rd_o[1]),
    .rom_A(rom_a_o[1]), .rom_CS_b(rom_cs_o[1]), .rom_OE_b(rom_oe_o[1]),
    .rom_Dout(rom_dout[1]), .busy(busy_o[1])
  );

  // Registered-read ROM per instance.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rom
    always @(posedge phi0) begin
      if (!rom_cs_o[gi]) rom_dout[gi] <= mem[rom_a_o[gi]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advances the model by one rising edge, using the inputs present at it.
  task automatic model_step();
    bit dw, cw;
    for (int k = 0; k < 2; k++) begin
      m_cpu_gnt[k] = 0; m_dbg_gnt[k] = 0; m_cpu_rv[k] = 0; m_dbg_rv[k] = 0;
      if (!rst_b) begin
        m_active[k] = 0; m_t[k] = 0; m_cnt[k] = 0; m_a[k] = '0; m_owner[k] = 0;
        m_cs_b[k] = 1; m_cpu_rd[k] = '0; m_dbg_rd[k] = '0;
      end else if (!m_active[k]) begin
        dw = DBG_EN && dbg_req && (!cpu_req || m_cnt[k] >= STARVE);
        cw = cpu_req && !dw;
        if (DBG_EN) begin
          if (!dbg_req || dw) m_cnt[k] = 0;
          else if (cw)        m_cnt[k] = m_cnt[k] + 1;
        end
        m_cs_b[k] = 1;
        if (cw || dw) begin
          m_active[k] = 1; m_t[k] = 0; m_owner[k] = dw; m_cs_b[k] = 0;
          m_a[k] = dw ? dbg_addr : cpu_addr;
          m_cpu_gnt[k] = cw; m_dbg_gnt[k] = dw;
        end
      end else begin
        m_t[k] = m_t[k] + 1;
        if (m_t[k] == WC[k] + 2) begin
          m_active[k] = 0;
          if (m_owner[k]) begin m_dbg_rd[k] = mem[m_a[k]]; m_dbg_rv[k] = 1; end
          else            begin m_cpu_rd[k] = mem[m_a[k]]; m_cpu_rv[k] = 1; end
          $display("u%0d %s read A=%04h D=%02h", k, m_owner[k] ? "DBG" : "CPU", m_a[k], mem[m_a[k]]);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.cpu_gnt", k),    32'(cpu_gnt_o[k]), 32'(m_cpu_gnt[k]));
      check($sformatf("u%0d.cpu_rvalid", k), 32'(cpu_rv_o[k]),  32'(m_cpu_rv[k]));
      check($sformatf("u%0d.cpu_rdata", k),  32'(cpu_rd_o[k]),  32'(m_cpu_rd[k]));
      check($sformatf("u%0d.dbg_gnt", k),    32'(dbg_gnt_o[k]), 32'(m_dbg_gnt[k]));
      check($sformatf("u%0d.dbg_rvalid", k), 32'(dbg_rv_o[k]),  32'(m_dbg_rv[k]));
      check($sformatf("u%0d.dbg_rdata", k),  32'(dbg_rd_o[k]),  32'(m_dbg_rd[k]));
      check($sformatf("u%0d.rom_A", k),      32'(rom_a_o[k]),   32'(m_a[k]));
      check($sformatf("u%0d.rom_CS_b", k),   32'(rom_cs_o[k]),  32'(m_cs_b[k]));
      check($sformatf("u%0d.rom_OE_b", k),   32'(rom_oe_o[k]),  32'(m_cs_b[k]));
      check($sformatf("u%0d.busy", k),       32'(busy_o[k]),    32'(m_active[k]));
    end
  endtask

  // One clock: edge, model update, compare on the falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge phi0);
      model_step();
      @(negedge phi0);
      compare_all();
    end
  endtask

  task automatic drive(input bit c, input logic [13:0] ca, input bit d, input logic [13:0] da);
    cpu_req = c; cpu_addr = ca; dbg_req = d; dbg_addr = da;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h0123] = 8'hA9;
    mem[14'h3FFF] = 8'h5C;
    mem[14'h0010] = 8'h77;
    rst_b = 1'b0;
    drive(0, 14'h0, 0, 14'h0);
    tick(3);
    rst_b = 1'b1;
    tick(2);

    // Single CPU read of 0x0123
    drive(1, 14'h0123, 0, 14'h0);
    tick(1);
    drive(0, 14'h0, 0, 14'h0);
    tick(8);
    check("t1_cpu_rdata", 32'(cpu_rd_o[0]), 32'h0000_00A9);

    // Debug read of 0x3FFF
    drive(0, 14'h0, 1, 14'h3FFF);
    tick(1);
    drive(0, 14'h0, 0, 14'h0);
    tick(8);
    check("t2_dbg_rdata", 32'(dbg_rd_o[1]), DBG_EN ? 32'h0000_005C : 32'h0);

    // Both held continuously: starvation guard
    for (int i = 0; i < 60; i++) begin
      drive(1, 14'($urandom), 1, 14'($urandom));
      tick(1);
    end
    drive(0, 14'h0, 0, 14'h0);
    tick(8);

    // Reset while the CPU read sits in ISSUE, then a fresh request
    drive(1, 14'h0123, 0, 14'h0);
    tick(1);
    drive(0, 14'h0, 0, 14'h0);
    rst_b = 1'b0;
    tick(1);
    rst_b = 1'b1;
    tick(3);
    drive(1, 14'h0010, 0, 14'h0);
    tick(1);
    drive(0, 14'h0, 0, 14'h0);
    tick(8);
    check("t4_cpu_rdata", 32'(cpu_rd_o[0]), 32'h0000_0077);

    // CPU pulse while a debug read is in flight
    drive(0, 14'h0, 1, 14'h0123);
    tick(1);
    drive(1, 14'h0200, 0, 14'h0);
    tick(1);
    drive(0, 14'h0, 0, 14'h0);
    tick(8);

    // Simultaneous CPU and debug request (debug addr 0x0010)
    drive(1, 14'h3FFF, 1, 14'h0010);
    tick(1);
    drive(0, 14'h0, 0, 14'h0);
    tick(8);
    check("t6_cpu_rdata", 32'(cpu_rd_o[1]), 32'h0000_005C);

    // Random traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      drive(1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 1)), 14'($urandom));
      rst_b = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_b = 1'b1;
    drive(0, 14'h0, 0, 14'h0);
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
